// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// 2-flop input synchroniser, false-start rejection, parity/framing/break flags.
module uart_rx_cfg #(
    parameter int CLOCKS_PER_BIT = 10416,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam bit               HAS_PAR   = (PARITY_MODE != 0);

    generate
        if (CLOCKS_PER_BIT < 4) begin : g_bad_cpb
            $error("uart_rx_cfg: CLOCKS_PER_BIT must be >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
            $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 frm_q, frm_d;
    logic                 brk_cand_q, brk_cand_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 r_rx;
    logic                 par_zero;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic x;
        x = (^data) ^ pbit;
        if (PARITY_MODE == 2) return x;
        if (PARITY_MODE == 1) return !x;
        return 1'b0;
    endfunction

    assign r_rx     = sync2_q;
    assign par_zero = !HAS_PAR || !par_bit_q;

    always_comb begin
        state_d    = state_q;
        sync1_d    = i_RX_Serial;
        sync2_d    = sync1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        frm_d      = frm_q;
        brk_cand_d = brk_cand_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!r_rx) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    frm_d      = 1'b0;
                    brk_cand_d = 1'b0;
                    state_d    = r_rx ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_d = {r_rx, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST_C) begin
                    cnt_d     = '0;
                    par_bit_d = r_rx;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    frm_d = frm_q | ~r_rx;
                    // Break is judged on the first stop bit; DV still waits for the last one.
                    if (idx_q == '0) brk_cand_d = (shift_q == '0) && par_zero && !r_rx;
                    if (idx_q == LAST_STOP) begin
                        dv_d    = 1'b1;
                        byte_d  = shift_q;
                        perr_d  = parity_error(shift_q, par_bit_q);
                        ferr_d  = frm_d;
                        brk_d   = brk_cand_d;
                        idx_d   = '0;
                        state_d = brk_cand_d ? S_BRK_WAIT : S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BRK_WAIT: begin
                cnt_d = '0;
                idx_d = '0;
                if (r_rx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            frm_q      <= 1'b0;
            brk_cand_q <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            frm_q      <= frm_d;
            brk_cand_q <= brk_cand_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign o_RX_DV      = dv_q;
    assign o_RX_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Break      = brk_q;
    assign o_Busy       = (state_q != S_IDLE);

endmodule
